// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: access sizes, error codes,
// FSM states and the store byte-strobe helper.
package lsu_pkg;

  localparam int unsigned D_SLICE_SIZE_DEFAULT = 32'd8192;

  typedef enum logic [1:0] {
    BYTE     = 2'b00,
    HALF     = 2'b01,
    WORD     = 2'b10,
    SIZE_ILL = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_RANGE    = 2'b10,
    ERR_SIZE     = 2'b11
  } lsu_err_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } lsu_state_e;

  // Byte strobes for a store of the given size at the given byte offset.
  function automatic logic [3:0] store_strobe(input lsu_size_e size, input logic [1:0] offset);
    logic [3:0] strobe;
    case (size)
      BYTE:    strobe = 4'b0001 << offset;
      HALF:    strobe = offset[1] ? 4'b1100 : 4'b0011;
      WORD:    strobe = 4'b1111;
      default: strobe = 4'b0000;
    endcase
    return strobe;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load lane extraction: picks the addressed byte/half out of the
// fetched SRAM word and sign- or zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] fetch,
  input  logic [1:0]  offset,
  input  lsu_size_e   size,
  input  logic        zero_ext,
  output logic [31:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection and extension.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    data   = 32'h0000_0000;
    case (offset)
      2'b00:   byte_s = fetch[7:0];
      2'b01:   byte_s = fetch[15:8];
      2'b10:   byte_s = fetch[23:16];
      2'b11:   byte_s = fetch[31:24];
      default: byte_s = 8'h00;
    endcase
    if (offset[1]) begin
      half_s = fetch[31:16];
    end else begin
      half_s = fetch[15:0];
    end
    case (size)
      BYTE:    data = zero_ext ? {24'h00_0000, byte_s} : {{24{byte_s[7]}}, byte_s};
      HALF:    data = zero_ext ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
      WORD:    data = fetch;
      default: data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the core request port and a data
// SRAM window; the SRAM does store lane steering, this block does load extraction.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned D_SLICE_SIZE = D_SLICE_SIZE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        data_enable,
  output logic        data_read,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] ram_address,
  output logic [31:0] ram_store,
  input  logic [31:0] ram_fetch
);

  localparam logic [31:0] SLICE_LIMIT = 32'(D_SLICE_SIZE);

  lsu_state_e  state_r;
  logic        we_r;
  lsu_size_e   size_r;
  logic        unsigned_r;
  logic [1:0]  offset_r;
  logic        resp_valid_r;
  logic [31:0] resp_rdata_r;
  lsu_err_e    resp_err_r;
  logic        data_enable_r;
  logic        data_read_r;
  logic [3:0]  wstrb_r;
  logic [31:0] ram_address_r;
  logic [31:0] ram_store_r;
  lsu_size_e   req_size_s;
  lsu_err_e    err_s;
  logic        misaligned_s;
  logic [31:0] load_data_s;

  assign req_size_s = lsu_size_e'(req_size);

  // Request error classification: illegal size beats misaligned beats out of range.
  always_comb begin
    err_s        = ERR_OK;
    misaligned_s = ((req_size_s == HALF) && req_addr[0]) ||
                   ((req_size_s == WORD) && (req_addr[1:0] != 2'b00));
    if (req_size_s == SIZE_ILL) begin
      err_s = ERR_SIZE;
    end else if (misaligned_s) begin
      err_s = ERR_MISALIGN;
    end else if (req_addr >= SLICE_LIMIT) begin
      err_s = ERR_RANGE;
    end else begin
      err_s = ERR_OK;
    end
  end

  lsu_load_align u_align (
    .fetch    (ram_fetch),
    .offset   (offset_r),
    .size     (size_r),
    .zero_ext (unsigned_r),
    .data     (load_data_s)
  );

  // Transaction FSM; SRAM and response outputs are registered on each transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      we_r          <= 1'b0;
      size_r        <= BYTE;
      unsigned_r    <= 1'b0;
      offset_r      <= 2'b00;
      resp_valid_r  <= 1'b0;
      resp_rdata_r  <= 32'h0000_0000;
      resp_err_r    <= ERR_OK;
      data_enable_r <= 1'b0;
      data_read_r   <= 1'b1;
      wstrb_r       <= 4'b0000;
      ram_address_r <= 32'h0000_0000;
      ram_store_r   <= 32'h0000_0000;
    end else begin
      resp_valid_r  <= 1'b0;
      data_enable_r <= 1'b0;
      data_read_r   <= 1'b1;
      wstrb_r       <= 4'b0000;
      ram_address_r <= 32'h0000_0000;
      ram_store_r   <= 32'h0000_0000;
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            we_r         <= req_we;
            size_r       <= req_size_s;
            unsigned_r   <= req_unsigned;
            offset_r     <= req_addr[1:0];
            resp_rdata_r <= 32'h0000_0000;
            resp_err_r   <= err_s;
            if (err_s != ERR_OK) begin
              resp_valid_r <= 1'b1;
              state_r      <= RESP;
            end else begin
              data_enable_r <= 1'b1;
              data_read_r   <= ~req_we;
              wstrb_r       <= req_we ? store_strobe(req_size_s, req_addr[1:0]) : 4'b0000;
              ram_address_r <= req_addr;
              ram_store_r   <= req_wdata;
              state_r       <= ISSUE;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          if (we_r) begin
            resp_valid_r <= 1'b1;
            state_r      <= RESP;
          end else begin
            state_r <= WAIT;
          end
        end
        WAIT: begin
          resp_rdata_r <= load_data_s;
          resp_valid_r <= 1'b1;
          state_r      <= RESP;
        end
        RESP: begin
          resp_rdata_r <= 32'h0000_0000;
          resp_err_r   <= ERR_OK;
          state_r      <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign req_ready   = (state_r == IDLE) && !rst;
  assign resp_valid  = resp_valid_r;
  assign resp_rdata  = resp_rdata_r;
  assign resp_err    = resp_err_r;
  assign data_enable = data_enable_r;
  assign data_read   = data_read_r;
  assign mem_wstrb   = wstrb_r;
  assign ram_address = ram_address_r;
  assign ram_store   = ram_store_r;

endmodule
